issue_unit: RTL and testbench
=============================

ISSUE_UNIT -- requirements
Module: issue

Interface
REQ-001 Parameter: none; all sizes fixed (8-entry ROB, 16 registers, 16-bit data).
REQ-002 clk1  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 in_valid  input  1  instruction presented this cycle.
REQ-005 func  input  4  opcode: 0 add, 1 sub, 2 mul, 3 div, 4 load, 5 store, 6 beq, 7 bneq, 8-15 illegal.
REQ-006 rs1, rs2, rd  input  4 each  instruction fields (inst[11:8], [7:4], [3:0]); for branches rd is imm; for load/store rs1 is address register.
REQ-007 cdb_valid, cdb_tag[2:0], cdb_data[15:0]  input  result broadcast from execution units.
REQ-008 issue_ok  output  1  instruction accepted this cycle (registered).
REQ-009 stall  output  1  combinational: in_valid high and instruction cannot issue.
REQ-010 issue_tag  output  3  ROB index allocated; issue_class  output  2  (0 add/sub, 1 mul/div, 2 load/store, 3 branch).
REQ-011 src1_rdy, src2_rdy  output  1; src1_val, src2_val  output  16; src1_tag, src2_tag  output  3  operand state captured at issue.
REQ-012 commit_valid  output  1; commit_rd  output  4; commit_data  output  16  retirement port.

Function
REQ-013 Capacity: add/sub station 3, mul/div station 3, load/store queue 4, branch station 2, ROB 8 (head_p, tail_p 3-bit, wrap 7->0, separate count 0-8).
REQ-014 Issue when in_valid, func legal, ROB count<8, and target station has a free entry; else stall=1, no state change.
REQ-015 Illegal func: stall=0, issue_ok=0, instruction dropped.
REQ-016 On issue: ROB[tail] = {busy, ready=0, dest=rd, writes_reg}; tail_p+1; station entry stores func, tags/values, ROB tag.
REQ-017 writes_reg=1 for func 0-4, 0 for store/branch; only writes_reg entries set reg status[rd]=tag.
REQ-018 Operand read: reg status clear -> rdy=1, val=regbank; status busy with ROB entry ready -> rdy=1, val=ROB value; else rdy=0, tag=status; load/branch use rs1 (branch also rs2); store uses rs1 and rs2.
REQ-019 Same-cycle CDB tag matching a source operand: operand forwarded as ready with cdb_data.
REQ-020 CDB: ROB[cdb_tag] ready=1, value=cdb_data; every station entry waiting on cdb_tag captures value; station entry whose own tag equals cdb_tag is freed.
REQ-021 Commit: one per cycle when ROB[head] busy and ready; writes regbank[dest] if writes_reg; clears reg status only if it still equals head tag; head_p+1; commit_valid pulses one cycle.
REQ-022 Commit and issue in same cycle permitted; freed ROB slot usable next cycle only.
REQ-023 Issue to rd equal to rs1/rs2 reads old mapping before renaming.
REQ-024 Station entry selection: lowest-index free entry.

Reset
REQ-025 rst: head_p=tail_p=0, count=0, all station/ROB busy=0, reg status clear, regbank[i]=i, all outputs 0.
REQ-026 rst dominates in_valid, cdb_valid and commit in same cycle.

Configuration
REQ-027 Macro ISSUE_TRACE_EN: defined -> simulation $display of pc-independent decoded func, rs1, rs2, rd on each issue; undefined -> no display code, identical logic.

Verification
REQ-028 After rst, add r1,r2->r3 (func0,rs1=1,rs2=2,rd=3) -> issue_ok=1, tag=0, class=0, src1_val=1, src2_val=2, both rdy.
REQ-029 Four add/sub back-to-back with no CDB -> fourth stalls, stall=1, tail_p=3.
REQ-030 add ->r3 then sub r3,r1->r4 -> second issue src1_rdy=0, src1_tag=0; cdb tag0 data 0x0005 -> station captures 5; commit writes regbank[3]=5.
REQ-031 Nine instructions, classes mixed, no CDB -> ROB full at 8, ninth stalls; CDB tag0 then commit -> ninth issues next cycle with tag 0 (wrap).
REQ-032 Store then branch -> commit_valid pulses, regbank unchanged, reg status unchanged.
REQ-033 rst asserted mid-stream with pending entries -> all busy bits 0, next issue gets tag 0.

Source files
------------

// File: rtl/issue_unit.sv
// issue_unit: Tomasulo-style issue stage with an 8-entry ROB, four reservation stations and in-order commit.
// Build option ISSUE_TRACE_EN adds a simulation-only trace line for every issued instruction.
module issue_unit (
    input  logic        clk1,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [3:0]  func,
    input  logic [3:0]  rs1,
    input  logic [3:0]  rs2,
    input  logic [3:0]  rd,
    input  logic        cdb_valid,
    input  logic [2:0]  cdb_tag,
    input  logic [15:0] cdb_data,
    input  logic [3:0]  dbg_ent_sel,
    output logic        issue_ok,
    output logic        stall,
    output logic [2:0]  issue_tag,
    output logic [1:0]  issue_class,
    output logic        src1_rdy,
    output logic        src2_rdy,
    output logic [15:0] src1_val,
    output logic [15:0] src2_val,
    output logic [2:0]  src1_tag,
    output logic [2:0]  src2_tag,
    output logic        commit_valid,
    output logic [3:0]  commit_rd,
    output logic [15:0] commit_data,
    output logic [2:0]  dbg_head_p,
    output logic [2:0]  dbg_tail_p,
    output logic [3:0]  dbg_rob_count,
    output logic [11:0] dbg_rs_busy,
    output logic [15:0] dbg_reg_busy,
    output logic        dbg_ent_rdy1,
    output logic        dbg_ent_rdy2,
    output logic [15:0] dbg_ent_val1,
    output logic [15:0] dbg_ent_val2
);
    typedef struct packed {
        logic        busy;
        logic        ready;
        logic [3:0]  dest;
        logic        writes_reg;
        logic [15:0] value;
    } rob_t;

    typedef struct packed {
        logic        busy;
        logic [3:0]  func;
        logic        rdy1;
        logic        rdy2;
        logic [15:0] val1;
        logic [15:0] val2;
        logic [2:0]  tag1;
        logic [2:0]  tag2;
        logic [2:0]  rob_tag;
    } rs_t;

    typedef struct packed {
        logic        rdy;
        logic [15:0] val;
        logic [2:0]  tag;
    } opnd_t;

    typedef struct packed {
        logic        ok;
        logic [2:0]  tag;
        logic [1:0]  cls;
        opnd_t       s1;
        opnd_t       s2;
    } iss_out_t;

    typedef struct packed {
        logic        valid;
        logic [3:0]  rd;
        logic [15:0] data;
    } com_out_t;

    // Stations share one array: add/sub 0-2, mul/div 3-5, load/store 6-9, branch 10-11.
    rob_t        rob_q [8];
    rob_t        rob_d [8];
    rs_t         rs_q [12];
    rs_t         rs_d [12];
    logic [15:0] regbank_q [16];
    logic [15:0] regbank_d [16];
    logic [2:0]  stat_tag_q [16];
    logic [2:0]  stat_tag_d [16];
    logic [15:0] stat_busy_q, stat_busy_d;
    logic [2:0]  head_q, head_d, tail_q, tail_d;
    logic [3:0]  count_q, count_d;
    iss_out_t    iss_q, iss_d;
    com_out_t    com_q, com_d;

    logic        legal, wr_reg, free_found, can_issue, do_commit;
    logic [1:0]  cls;
    logic [3:0]  free_idx, r;
    logic [2:0]  st;
    opnd_t       op [2];
    int          lo, hi;

    always_comb begin
        legal = 1'b1;
        cls   = 2'd0;
        case (func)
            4'd0, 4'd1: cls = 2'd0;
            4'd2, 4'd3: cls = 2'd1;
            4'd4, 4'd5: cls = 2'd2;
            4'd6, 4'd7: cls = 2'd3;
            default:    legal = 1'b0;
        endcase
        wr_reg = (func <= 4'd4);
        case (cls)
            2'd0:    begin lo = 0;  hi = 2;  end
            2'd1:    begin lo = 3;  hi = 5;  end
            2'd2:    begin lo = 6;  hi = 9;  end
            default: begin lo = 10; hi = 11; end
        endcase
        free_found = 1'b0;
        free_idx   = 4'd0;
        for (int i = 11; i >= 0; i--) begin
            if (i >= lo && i <= hi && !rs_q[i].busy) begin
                free_found = 1'b1;
                free_idx   = 4'(i);
            end
        end
        can_issue = in_valid && legal && (count_q < 4'd8) && free_found;
        stall     = in_valid && legal && !can_issue;
        do_commit = rob_q[head_q].busy && rob_q[head_q].ready;

        // Operands see the mapping before this instruction renames rd.
        r     = '0;
        st    = '0;
        op[0] = '0;
        op[1] = '0;
        for (int k = 0; k < 2; k++) begin
            r = (k == 0) ? rs1 : rs2;
            op[k].rdy = 1'b1;
            op[k].val = regbank_q[r];
            op[k].tag = 3'd0;
            if (stat_busy_q[r]) begin
                st = stat_tag_q[r];
                if (rob_q[st].ready) begin
                    op[k].val = rob_q[st].value;
                end else if (cdb_valid && cdb_tag == st) begin
                    op[k].val = cdb_data;
                end else begin
                    op[k].rdy = 1'b0;
                    op[k].val = 16'd0;
                    op[k].tag = st;
                end
            end
        end
        if (func == 4'd4) op[1] = '{rdy: 1'b1, val: 16'd0, tag: 3'd0};

        rob_d       = rob_q;
        rs_d        = rs_q;
        regbank_d   = regbank_q;
        stat_busy_d = stat_busy_q;
        stat_tag_d  = stat_tag_q;
        head_d      = head_q;
        tail_d      = tail_q;
        if (cdb_valid) begin
            if (rob_q[cdb_tag].busy) begin
                rob_d[cdb_tag].ready = 1'b1;
                rob_d[cdb_tag].value = cdb_data;
            end
            for (int i = 0; i < 12; i++) begin
                if (rs_q[i].busy) begin
                    if (!rs_q[i].rdy1 && rs_q[i].tag1 == cdb_tag) begin
                        rs_d[i].rdy1 = 1'b1;
                        rs_d[i].val1 = cdb_data;
                    end
                    if (!rs_q[i].rdy2 && rs_q[i].tag2 == cdb_tag) begin
                        rs_d[i].rdy2 = 1'b1;
                        rs_d[i].val2 = cdb_data;
                    end
                    if (rs_q[i].rob_tag == cdb_tag) rs_d[i].busy = 1'b0;
                end
            end
        end

        com_d       = com_q;
        com_d.valid = do_commit;
        if (do_commit) begin
            rob_d[head_q].busy  = 1'b0;
            rob_d[head_q].ready = 1'b0;
            if (rob_q[head_q].writes_reg) begin
                regbank_d[rob_q[head_q].dest] = rob_q[head_q].value;
                if (stat_busy_q[rob_q[head_q].dest] && stat_tag_q[rob_q[head_q].dest] == head_q)
                    stat_busy_d[rob_q[head_q].dest] = 1'b0;
            end
            head_d     = head_q + 3'd1;
            com_d.rd   = rob_q[head_q].dest;
            com_d.data = rob_q[head_q].value;
        end

        // Issue is applied last so a same-cycle rename overrides the commit's status clear.
        iss_d    = iss_q;
        iss_d.ok = can_issue;
        if (can_issue) begin
            rob_d[tail_q] = '{busy: 1'b1, ready: 1'b0, dest: rd, writes_reg: wr_reg, value: 16'd0};
            rs_d[free_idx] = '{busy: 1'b1, func: func, rdy1: op[0].rdy, rdy2: op[1].rdy,
                               val1: op[0].val, val2: op[1].val, tag1: op[0].tag,
                               tag2: op[1].tag, rob_tag: tail_q};
            if (wr_reg) begin
                stat_busy_d[rd] = 1'b1;
                stat_tag_d[rd]  = tail_q;
            end
            tail_d    = tail_q + 3'd1;
            iss_d.tag = tail_q;
            iss_d.cls = cls;
            iss_d.s1  = op[0];
            iss_d.s2  = op[1];
        end
        count_d = count_q + {3'd0, can_issue} - {3'd0, do_commit};
    end

    always_ff @(posedge clk1) begin
        if (rst) begin
            head_q      <= 3'd0;
            tail_q      <= 3'd0;
            count_q     <= 4'd0;
            stat_busy_q <= 16'd0;
            iss_q       <= '0;
            com_q       <= '0;
            for (int i = 0; i < 8; i++) rob_q[i] <= '0;
            for (int i = 0; i < 12; i++) rs_q[i] <= '0;
            for (int i = 0; i < 16; i++) begin
                regbank_q[i]  <= 16'(i);
                stat_tag_q[i] <= 3'd0;
            end
        end else begin
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            stat_busy_q <= stat_busy_d;
            iss_q       <= iss_d;
            com_q       <= com_d;
            rob_q       <= rob_d;
            rs_q        <= rs_d;
            regbank_q   <= regbank_d;
            stat_tag_q  <= stat_tag_d;
        end
    end

`ifdef ISSUE_TRACE_EN
    always_ff @(posedge clk1) begin
        if (!rst && can_issue)
            $display("issue: func=%0d rs1=%0d rs2=%0d rd=%0d", func, rs1, rs2, rd);
    end
`else
    // Default build carries no trace logic.
`endif

    always_comb begin
        dbg_rs_busy = '0;
        for (int i = 0; i < 12; i++) dbg_rs_busy[i] = rs_q[i].busy;
    end

    assign issue_ok      = iss_q.ok;
    assign issue_tag     = iss_q.tag;
    assign issue_class   = iss_q.cls;
    assign src1_rdy      = iss_q.s1.rdy;
    assign src1_val      = iss_q.s1.val;
    assign src1_tag      = iss_q.s1.tag;
    assign src2_rdy      = iss_q.s2.rdy;
    assign src2_val      = iss_q.s2.val;
    assign src2_tag      = iss_q.s2.tag;
    assign commit_valid  = com_q.valid;
    assign commit_rd     = com_q.rd;
    assign commit_data   = com_q.data;
    assign dbg_head_p    = head_q;
    assign dbg_tail_p    = tail_q;
    assign dbg_rob_count = count_q;
    assign dbg_reg_busy  = stat_busy_q;
    assign dbg_ent_rdy1  = rs_q[dbg_ent_sel].rdy1;
    assign dbg_ent_rdy2  = rs_q[dbg_ent_sel].rdy2;
    assign dbg_ent_val1  = rs_q[dbg_ent_sel].val1;
    assign dbg_ent_val2  = rs_q[dbg_ent_sel].val2;
endmodule

// File: tb/tb_issue_unit.sv
// Directed bench for issue_unit: reset, operand capture, stalls, CDB forwarding, ROB wrap, commit and mid-stream reset.
module tb_issue_unit;
    logic        clk1 = 1'b0;
    logic        rst, in_valid, cdb_valid;
    logic [3:0]  func, rs1, rs2, rd, dbg_ent_sel;
    logic [2:0]  cdb_tag;
    logic [15:0] cdb_data;
    logic        issue_ok, stall, src1_rdy, src2_rdy, commit_valid;
    logic [2:0]  issue_tag, src1_tag, src2_tag, dbg_head_p, dbg_tail_p;
    logic [1:0]  issue_class;
    logic [15:0] src1_val, src2_val, commit_data, dbg_reg_busy, dbg_ent_val1, dbg_ent_val2;
    logic [3:0]  commit_rd, dbg_rob_count;
    logic [11:0] dbg_rs_busy;
    logic        dbg_ent_rdy1, dbg_ent_rdy2;
    int          total = 0;
    int          bad = 0;

    issue_unit dut (
        .clk1(clk1), .rst(rst), .in_valid(in_valid), .func(func), .rs1(rs1), .rs2(rs2), .rd(rd),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data), .dbg_ent_sel(dbg_ent_sel),
        .issue_ok(issue_ok), .stall(stall), .issue_tag(issue_tag), .issue_class(issue_class),
        .src1_rdy(src1_rdy), .src2_rdy(src2_rdy), .src1_val(src1_val), .src2_val(src2_val),
        .src1_tag(src1_tag), .src2_tag(src2_tag), .commit_valid(commit_valid),
        .commit_rd(commit_rd), .commit_data(commit_data), .dbg_head_p(dbg_head_p),
        .dbg_tail_p(dbg_tail_p), .dbg_rob_count(dbg_rob_count), .dbg_rs_busy(dbg_rs_busy),
        .dbg_reg_busy(dbg_reg_busy), .dbg_ent_rdy1(dbg_ent_rdy1), .dbg_ent_rdy2(dbg_ent_rdy2),
        .dbg_ent_val1(dbg_ent_val1), .dbg_ent_val2(dbg_ent_val2)
    );

    always #5 clk1 = ~clk1;

    task automatic step();
        @(posedge clk1);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid = 0; cdb_valid = 0; func = 0; rs1 = 0; rs2 = 0; rd = 0;
        cdb_tag = 0; cdb_data = 0; dbg_ent_sel = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1;
        step();
        rst = 0;
    endtask

    task automatic issue(input logic [3:0] f, input logic [3:0] a, input logic [3:0] b, input logic [3:0] d);
        in_valid = 1; func = f; rs1 = a; rs2 = b; rd = d;
        step();
        in_valid = 0;
    endtask

    task automatic cdb(input logic [2:0] t, input logic [15:0] v);
        cdb_valid = 1; cdb_tag = t; cdb_data = v;
        step();
        cdb_valid = 0;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (issue_ok !== 1'b0) begin bad++; $display("FAIL rst_issue_ok: got %0d want 0", issue_ok); end
        total++; if (commit_valid !== 1'b0) begin bad++; $display("FAIL rst_commit_valid: got %0d want 0", commit_valid); end
        total++; if (dbg_tail_p !== 3'd0) begin bad++; $display("FAIL rst_tail: got %0d want 0", dbg_tail_p); end
        total++; if (dbg_rob_count !== 4'd0) begin bad++; $display("FAIL rst_count: got %0d want 0", dbg_rob_count); end
        total++; if (dbg_rs_busy !== 12'h000) begin bad++; $display("FAIL rst_rs_busy: got %0h want 0", dbg_rs_busy); end
        total++; if (src1_val !== 16'h0000) begin bad++; $display("FAIL rst_src1_val: got %0h want 0", src1_val); end
    endtask

    task automatic test_basic_add();
        issue(4'd0, 4'd1, 4'd2, 4'd3);
        total++; if (issue_ok !== 1'b1) begin bad++; $display("FAIL add_issue_ok: got %0d want 1", issue_ok); end
        total++; if (issue_tag !== 3'd0) begin bad++; $display("FAIL add_tag: got %0d want 0", issue_tag); end
        total++; if (issue_class !== 2'd0) begin bad++; $display("FAIL add_class: got %0d want 0", issue_class); end
        total++; if ({src1_rdy, src2_rdy} !== 2'b11) begin bad++; $display("FAIL add_rdy: got %b want 11", {src1_rdy, src2_rdy}); end
        total++; if (src1_val !== 16'd1) begin bad++; $display("FAIL add_src1_val: got %0h want 1", src1_val); end
        total++; if (src2_val !== 16'd2) begin bad++; $display("FAIL add_src2_val: got %0h want 2", src2_val); end
        total++; if (dbg_reg_busy !== 16'h0008) begin bad++; $display("FAIL add_reg_busy: got %0h want 8", dbg_reg_busy); end
    endtask

    task automatic test_stall_and_illegal();
        do_reset();
        issue(4'd0, 4'd1, 4'd2, 4'd4);
        issue(4'd1, 4'd1, 4'd2, 4'd5);
        issue(4'd0, 4'd1, 4'd2, 4'd6);
        in_valid = 1; func = 4'd1; rs1 = 4'd1; rs2 = 4'd2; rd = 4'd7;
        #1;
        total++; if (stall !== 1'b1) begin bad++; $display("FAIL full_stall: got %0d want 1", stall); end
        step();
        total++; if (issue_ok !== 1'b0) begin bad++; $display("FAIL full_issue_ok: got %0d want 0", issue_ok); end
        total++; if (dbg_tail_p !== 3'd3) begin bad++; $display("FAIL full_tail: got %0d want 3", dbg_tail_p); end
        total++; if (dbg_rs_busy !== 12'h007) begin bad++; $display("FAIL full_rs_busy: got %0h want 7", dbg_rs_busy); end
        func = 4'd9;
        #1;
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL illegal_stall: got %0d want 0", stall); end
        step();
        in_valid = 0;
        total++; if (issue_ok !== 1'b0) begin bad++; $display("FAIL illegal_issue_ok: got %0d want 0", issue_ok); end
        total++; if (dbg_rob_count !== 4'd3) begin bad++; $display("FAIL illegal_count: got %0d want 3", dbg_rob_count); end
    endtask

    task automatic test_dependency();
        do_reset();
        issue(4'd0, 4'd1, 4'd2, 4'd3);
        issue(4'd1, 4'd3, 4'd1, 4'd4);
        total++; if (issue_tag !== 3'd1) begin bad++; $display("FAIL dep_tag: got %0d want 1", issue_tag); end
        total++; if (src1_rdy !== 1'b0) begin bad++; $display("FAIL dep_src1_rdy: got %0d want 0", src1_rdy); end
        total++; if (src1_tag !== 3'd0) begin bad++; $display("FAIL dep_src1_tag: got %0d want 0", src1_tag); end
        total++; if (src2_val !== 16'd1) begin bad++; $display("FAIL dep_src2_val: got %0h want 1", src2_val); end
        dbg_ent_sel = 4'd1;
        cdb(3'd0, 16'h0005);
        total++; if (dbg_ent_rdy1 !== 1'b1) begin bad++; $display("FAIL dep_capture_rdy: got %0d want 1", dbg_ent_rdy1); end
        total++; if (dbg_ent_val1 !== 16'h0005) begin bad++; $display("FAIL dep_capture_val: got %0h want 5", dbg_ent_val1); end
        total++; if (dbg_rs_busy !== 12'h002) begin bad++; $display("FAIL dep_rs_free: got %0h want 2", dbg_rs_busy); end
        total++; if (commit_valid !== 1'b0) begin bad++; $display("FAIL dep_early_commit: got %0d want 0", commit_valid); end
        step();
        total++; if (commit_valid !== 1'b1) begin bad++; $display("FAIL dep_commit_valid: got %0d want 1", commit_valid); end
        total++; if (commit_rd !== 4'd3) begin bad++; $display("FAIL dep_commit_rd: got %0d want 3", commit_rd); end
        total++; if (commit_data !== 16'h0005) begin bad++; $display("FAIL dep_commit_data: got %0h want 5", commit_data); end
        total++; if (dbg_reg_busy !== 16'h0010) begin bad++; $display("FAIL dep_reg_busy: got %0h want 10", dbg_reg_busy); end
        issue(4'd0, 4'd3, 4'd0, 4'd5);
        total++; if (src1_val !== 16'h0005 || src1_rdy !== 1'b1) begin bad++; $display("FAIL dep_regbank: got %0h want 5", src1_val); end
        total++; if (issue_tag !== 3'd2) begin bad++; $display("FAIL dep_tag2: got %0d want 2", issue_tag); end
    endtask

    task automatic test_cdb_forward_and_rename();
        do_reset();
        issue(4'd0, 4'd1, 4'd2, 4'd3);
        cdb_valid = 1; cdb_tag = 3'd0; cdb_data = 16'h0007;
        issue(4'd1, 4'd3, 4'd3, 4'd4);
        cdb_valid = 0;
        total++; if ({src1_rdy, src2_rdy} !== 2'b11) begin bad++; $display("FAIL fwd_rdy: got %b want 11", {src1_rdy, src2_rdy}); end
        total++; if (src1_val !== 16'h0007) begin bad++; $display("FAIL fwd_src1_val: got %0h want 7", src1_val); end
        total++; if (src2_val !== 16'h0007) begin bad++; $display("FAIL fwd_src2_val: got %0h want 7", src2_val); end
        do_reset();
        issue(4'd2, 4'd1, 4'd2, 4'd1);
        total++; if (src1_val !== 16'd1 || src1_rdy !== 1'b1) begin bad++; $display("FAIL rename_old: got %0h want 1", src1_val); end
        issue(4'd3, 4'd1, 4'd1, 4'd2);
        total++; if (src1_rdy !== 1'b0 || src1_tag !== 3'd0) begin bad++; $display("FAIL rename_new: got rdy=%0d tag=%0d want rdy=0 tag=0", src1_rdy, src1_tag); end
        total++; if (issue_class !== 2'd1) begin bad++; $display("FAIL rename_class: got %0d want 1", issue_class); end
    endtask

    task automatic test_rob_full_wrap();
        do_reset();
        issue(4'd0, 4'd1, 4'd2, 4'd5);
        issue(4'd1, 4'd1, 4'd2, 4'd6);
        issue(4'd2, 4'd1, 4'd2, 4'd7);
        issue(4'd3, 4'd1, 4'd2, 4'd8);
        issue(4'd4, 4'd1, 4'd0, 4'd9);
        issue(4'd4, 4'd1, 4'd0, 4'd10);
        issue(4'd6, 4'd1, 4'd2, 4'd3);
        issue(4'd5, 4'd1, 4'd2, 4'd0);
        total++; if (issue_tag !== 3'd7 || issue_class !== 2'd2) begin bad++; $display("FAIL wrap_eighth: got tag=%0d cls=%0d want tag=7 cls=2", issue_tag, issue_class); end
        total++; if (dbg_rob_count !== 4'd8 || dbg_tail_p !== 3'd0) begin bad++; $display("FAIL wrap_full: got count=%0d tail=%0d want 8/0", dbg_rob_count, dbg_tail_p); end
        in_valid = 1; func = 4'd0; rs1 = 4'd1; rs2 = 4'd2; rd = 4'd11;
        #1;
        total++; if (stall !== 1'b1) begin bad++; $display("FAIL wrap_stall: got %0d want 1", stall); end
        cdb_valid = 1; cdb_tag = 3'd0; cdb_data = 16'h1234;
        step();
        cdb_valid = 0;
        total++; if (issue_ok !== 1'b0 || stall !== 1'b1) begin bad++; $display("FAIL wrap_cdb_cycle: got ok=%0d stall=%0d want 0/1", issue_ok, stall); end
        step();
        total++; if (commit_valid !== 1'b1 || commit_rd !== 4'd5 || commit_data !== 16'h1234) begin bad++; $display("FAIL wrap_commit: got v=%0d rd=%0d d=%0h want 1/5/1234", commit_valid, commit_rd, commit_data); end
        total++; if (issue_ok !== 1'b0 || dbg_rob_count !== 4'd7) begin bad++; $display("FAIL wrap_same_cycle: got ok=%0d count=%0d want 0/7", issue_ok, dbg_rob_count); end
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL wrap_unstall: got %0d want 0", stall); end
        step();
        in_valid = 0;
        total++; if (issue_ok !== 1'b1 || issue_tag !== 3'd0) begin bad++; $display("FAIL wrap_ninth: got ok=%0d tag=%0d want 1/0", issue_ok, issue_tag); end
        total++; if (dbg_rob_count !== 4'd8 || dbg_tail_p !== 3'd1 || dbg_head_p !== 3'd1) begin bad++; $display("FAIL wrap_ptrs: got count=%0d tail=%0d head=%0d want 8/1/1", dbg_rob_count, dbg_tail_p, dbg_head_p); end
    endtask

    task automatic test_store_branch();
        do_reset();
        issue(4'd5, 4'd1, 4'd2, 4'd3);
        issue(4'd6, 4'd4, 4'd5, 4'd6);
        total++; if (issue_class !== 2'd3) begin bad++; $display("FAIL sb_class: got %0d want 3", issue_class); end
        total++; if (dbg_reg_busy !== 16'h0000) begin bad++; $display("FAIL sb_no_rename: got %0h want 0", dbg_reg_busy); end
        cdb(3'd0, 16'h00AA);
        cdb(3'd1, 16'h0001);
        total++; if (commit_valid !== 1'b1) begin bad++; $display("FAIL sb_commit_store: got %0d want 1", commit_valid); end
        step();
        total++; if (commit_valid !== 1'b1 || dbg_head_p !== 3'd2) begin bad++; $display("FAIL sb_commit_branch: got v=%0d head=%0d want 1/2", commit_valid, dbg_head_p); end
        step();
        total++; if (commit_valid !== 1'b0) begin bad++; $display("FAIL sb_commit_pulse: got %0d want 0", commit_valid); end
        issue(4'd0, 4'd3, 4'd6, 4'd7);
        total++; if (src1_val !== 16'd3 || src2_val !== 16'd6) begin bad++; $display("FAIL sb_regbank: got %0h/%0h want 3/6", src1_val, src2_val); end
        total++; if (dbg_reg_busy !== 16'h0080) begin bad++; $display("FAIL sb_reg_busy: got %0h want 80", dbg_reg_busy); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        issue(4'd0, 4'd1, 4'd2, 4'd3);
        issue(4'd2, 4'd4, 4'd5, 4'd6);
        rst = 1; in_valid = 1; func = 4'd0; rs1 = 4'd1; rs2 = 4'd2; rd = 4'd7;
        cdb_valid = 1; cdb_tag = 3'd0; cdb_data = 16'h0099;
        step();
        rst = 0; in_valid = 0; cdb_valid = 0;
        total++; if (issue_ok !== 1'b0 || commit_valid !== 1'b0) begin bad++; $display("FAIL mid_outputs: got ok=%0d cv=%0d want 0/0", issue_ok, commit_valid); end
        total++; if (dbg_rs_busy !== 12'h000 || dbg_reg_busy !== 16'h0000) begin bad++; $display("FAIL mid_busy: got rs=%0h reg=%0h want 0/0", dbg_rs_busy, dbg_reg_busy); end
        total++; if (dbg_rob_count !== 4'd0 || dbg_tail_p !== 3'd0) begin bad++; $display("FAIL mid_ptrs: got count=%0d tail=%0d want 0/0", dbg_rob_count, dbg_tail_p); end
        issue(4'd0, 4'd1, 4'd2, 4'd3);
        total++; if (issue_ok !== 1'b1 || issue_tag !== 3'd0 || src1_val !== 16'd1) begin bad++; $display("FAIL mid_reissue: got ok=%0d tag=%0d v=%0h want 1/0/1", issue_ok, issue_tag, src1_val); end
    endtask

    initial begin
        test_reset();
        test_basic_add();
        test_stall_and_illegal();
        test_dependency();
        test_cdb_forward_and_rename();
        test_rob_full_wrap();
        test_store_branch();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
